// File: rtl/stream_accumulator.sv
// Multi-channel signed AXI-Stream accumulator with one-entry result register.
// Build option: ACCUM_SATURATE_EN clamps on overflow instead of wrapping.
module stream_accumulator #(
   parameter int DATA_W   = 16,
   parameter int ACC_W    = 32,
   parameter int CHANNELS = 4,
   parameter int ID_W     = 2
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              clear,
   input  logic              s_axis_a_tvalid,
   output logic              s_axis_a_tready,
   input  logic [DATA_W-1:0] s_axis_a_tdata,
   input  logic              s_axis_a_tlast,
   input  logic [ID_W-1:0]   s_axis_a_tid,
   output logic              m_axis_result_tvalid,
   input  logic              m_axis_result_tready,
   output logic [ACC_W-1:0]  m_axis_result_tdata,
   output logic              m_axis_result_tlast,
   output logic [ID_W-1:0]   m_axis_result_tid,
   output logic              m_axis_result_tuser
);

   localparam logic [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W-1:0]    r_acc [CHANNELS];
   logic [CHANNELS-1:0] r_ovf;
   logic                r_ovalid;
   logic [ACC_W-1:0]    r_odata;
   logic [ID_W-1:0]     r_oid;
   logic                r_ouser;

   logic               w_accept;
   logic               w_hit;
   logic [ACC_W-1:0]   w_cur;
   logic               w_ovf_cur;
   logic [ACC_W:0]     w_sext;
   logic [ACC_W:0]     w_sum;
   logic               w_ov;
   logic [ACC_W-1:0]   w_res;

   assign s_axis_a_tready = !r_ovalid | m_axis_result_tready;
   assign w_accept        = s_axis_a_tvalid & s_axis_a_tready;

   // clear takes effect before a same-cycle beat, so it sees a zero total
   always_comb begin
      w_hit     = 1'b0;
      w_cur     = '0;
      w_ovf_cur = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (s_axis_a_tid == ID_W'(c)) begin
            w_hit     = 1'b1;
            w_cur     = r_acc[c];
            w_ovf_cur = r_ovf[c];
         end
      end
      if (clear) begin
         w_cur     = '0;
         w_ovf_cur = 1'b0;
      end
   end

   assign w_sext = {{(ACC_W+1-DATA_W){s_axis_a_tdata[DATA_W-1]}},
                    s_axis_a_tdata};
   assign w_sum  = {w_cur[ACC_W-1], w_cur} + w_sext;
   assign w_ov   = w_sum[ACC_W] ^ w_sum[ACC_W-1];

`ifdef ACCUM_SATURATE_EN
   assign w_res = !w_ov ? w_sum[ACC_W-1:0] :
                  (w_sum[ACC_W] ? MINV : MAXV);
`else
   assign w_res = w_sum[ACC_W-1:0];
`endif

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int c = 0; c < CHANNELS; c++) r_acc[c] <= '0;
         r_ovf <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (clear) begin
               r_acc[c] <= '0;
               r_ovf[c] <= 1'b0;
            end
            if (w_accept && s_axis_a_tid == ID_W'(c)) begin
               if (s_axis_a_tlast) begin
                  r_acc[c] <= '0;
                  r_ovf[c] <= 1'b0;
               end else begin
                  r_acc[c] <= w_res;
                  r_ovf[c] <= w_ovf_cur | w_ov;
               end
            end
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_ovalid <= 1'b0;
         r_odata  <= '0;
         r_oid    <= '0;
         r_ouser  <= 1'b0;
      end else begin
         if (m_axis_result_tready) r_ovalid <= 1'b0;
         if (w_accept && s_axis_a_tlast && w_hit) begin
            r_ovalid <= 1'b1;
            r_odata  <= w_res;
            r_oid    <= s_axis_a_tid;
            r_ouser  <= w_ovf_cur | w_ov;
         end
      end
   end

   assign m_axis_result_tvalid = r_ovalid;
   assign m_axis_result_tdata  = r_odata;
   assign m_axis_result_tlast  = r_ovalid;
   assign m_axis_result_tid    = r_oid;
   assign m_axis_result_tuser  = r_ouser;

endmodule

// File: tb/tb_stream_accumulator.sv
// Scoreboard bench for stream_accumulator (12-bit samples, 16-bit sums,
// 4 channels on a 3-bit id so out-of-range ids can be driven).
module tb_stream_accumulator;
   localparam int DW = 12;
   localparam int AW = 16;
   localparam int CH = 4;
   localparam int IW = 3;
   localparam int LIM = 1 << (AW-1);

   typedef struct {
      int ch;
      int data;
      bit user;
   } res_t;

   logic          aclk = 0;
   logic          areset = 1;
   logic          clear = 0;
   logic          s_tvalid = 0;
   logic          s_tready;
   logic [DW-1:0] s_tdata = '0;
   logic          s_tlast = 0;
   logic [IW-1:0] s_tid = '0;
   logic          m_tvalid;
   logic          m_tready = 1;
   logic [AW-1:0] m_tdata;
   logic          m_tlast;
   logic [IW-1:0] m_tid;
   logic          m_tuser;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int m_acc [8];
   bit m_ovf [8];
   res_t q [$];
   bit hold_v = 0;
   logic [AW-1:0] hold_d;
   logic [IW-1:0] hold_id;
   logic hold_u;

   stream_accumulator #(
      .DATA_W(DW), .ACC_W(AW), .CHANNELS(CH), .ID_W(IW)
   ) dut (
      .aclk(aclk),
      .areset(areset),
      .clear(clear),
      .s_axis_a_tvalid(s_tvalid),
      .s_axis_a_tready(s_tready),
      .s_axis_a_tdata(s_tdata),
      .s_axis_a_tlast(s_tlast),
      .s_axis_a_tid(s_tid),
      .m_axis_result_tvalid(m_tvalid),
      .m_axis_result_tready(m_tready),
      .m_axis_result_tdata(m_tdata),
      .m_axis_result_tlast(m_tlast),
      .m_axis_result_tid(m_tid),
      .m_axis_result_tuser(m_tuser)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc++;

   // reference model step for one accepted beat
   task automatic mstep(input int ch, input int d, input bit last,
                        input bit clr);
      int sum;
      int res;
      bit ov;
      res_t r;
      if (clr) begin
         for (int i = 0; i < 8; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 0;
         end
      end
      if (ch >= CH) return;
      sum = m_acc[ch] + d;
      ov  = (sum > LIM-1) || (sum < -LIM);
`ifdef ACCUM_SATURATE_EN
      res = !ov ? sum : (sum > 0 ? LIM-1 : -LIM);
`else
      res = !ov ? sum : (sum > 0 ? sum - 2*LIM : sum + 2*LIM);
`endif
      if (last) begin
         r.ch = ch;
         r.data = res;
         r.user = m_ovf[ch] | ov;
         q.push_back(r);
         m_acc[ch] = 0;
         m_ovf[ch] = 0;
      end else begin
         m_acc[ch] = res;
         m_ovf[ch] = m_ovf[ch] | ov;
      end
   endtask

   always @(negedge aclk) begin
      if (!areset) begin
         if (hold_v) begin
            total++;
            if (m_tvalid !== 1'b1 || m_tdata !== hold_d ||
                m_tid !== hold_id || m_tuser !== hold_u) begin
               bad++;
               $display("FAIL hold_stable: got v=%0b d=%h id=%0d u=%0b want d=%h id=%0d u=%0b",
                        m_tvalid, m_tdata, m_tid, m_tuser,
                        hold_d, hold_id, hold_u);
            end
         end
         if (m_tvalid && m_tready) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_result: got id=%0d d=%h",
                        m_tid, m_tdata);
            end else begin
               res_t e;
               logic [AW-1:0] ed;
               e = q.pop_front();
               ed = AW'(e.data);
               if (m_tdata !== ed || m_tid !== IW'(e.ch) ||
                   m_tuser !== e.user || m_tlast !== 1'b1) begin
                  bad++;
                  $display("FAIL result: got id=%0d d=%h u=%0b l=%0b want id=%0d d=%h u=%0b l=1",
                           m_tid, m_tdata, m_tuser, m_tlast,
                           e.ch, ed, e.user);
               end
            end
         end
         hold_v  = m_tvalid && !m_tready;
         hold_d  = m_tdata;
         hold_id = m_tid;
         hold_u  = m_tuser;
      end
   end

   task automatic send(input int ch, input int d, input bit last);
      int n;
      s_tvalid = 1;
      s_tid    = ch[IW-1:0];
      s_tdata  = d[DW-1:0];
      s_tlast  = last;
      n = 0;
      @(negedge aclk);
      while (!s_tready && n < 50) begin
         n++;
         @(negedge aclk);
      end
      total++;
      if (n >= 50) begin
         bad++;
         $display("FAIL send_timeout: tready=%0b after %0d cycles, want 1",
                  s_tready, n);
         s_tvalid = 0;
         s_tlast = 0;
         return;
      end
      mstep(ch, d, last, clear);
      @(posedge aclk);
      #1;
      s_tvalid = 0;
      s_tlast  = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      areset = 1;
      #1;
      q.delete();
      hold_v = 0;
      for (int i = 0; i < 8; i++) begin
         m_acc[i] = 0;
         m_ovf[i] = 0;
      end
      @(posedge aclk);
      #1;
      areset = 0;
   endtask

   task automatic test_reset();
      @(posedge aclk);
      #1;
      total++;
      if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || m_tdata !== '0 ||
          m_tlast !== 1'b0 || m_tid !== '0 || m_tuser !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got rdy=%0b v=%0b d=%h l=%0b id=%0d u=%0b want 1 0 0 0 0 0",
                  s_tready, m_tvalid, m_tdata, m_tlast, m_tid, m_tuser);
      end
      do_reset();
   endtask

   task automatic test_basic();
      send(0, 1, 0);
      send(0, 2, 0);
      send(0, 3, 1);
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== 16'd6 || m_tid !== 3'd0) begin
         bad++;
         $display("FAIL basic_latency: got v=%0b d=%0d id=%0d want v=1 d=6 id=0",
                  m_tvalid, m_tdata, m_tid);
      end
      idle(2);
      send(1, -7, 1);
      idle(2);
   endtask

   task automatic test_interleave();
      int c0;
      c0 = cyc;
      send(1, 10, 0);
      send(2, -4, 0);
      send(1, 5, 1);
      send(2, -6, 1);
      total++;
      if (cyc - c0 !== 4) begin
         bad++;
         $display("FAIL interleave_cycles: got %0d want 4", cyc - c0);
      end
      send(3, 1, 1);
      send(0, 2, 1);
      send(3, 3, 1);
      idle(3);
   endtask

   task automatic test_backpressure();
      m_tready = 0;
      send(1, 5, 1);
      fork
         send(2, 7, 1);
         begin
            repeat (5) begin
               @(negedge aclk);
               total++;
               if (s_tready !== 1'b0 || m_tvalid !== 1'b1) begin
                  bad++;
                  $display("FAIL stall: got rdy=%0b v=%0b want rdy=0 v=1",
                           s_tready, m_tvalid);
               end
            end
            @(posedge aclk);
            #1;
            m_tready = 1;
         end
      join
      idle(3);
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 17; i++) send(0, 2047, i == 16);
      for (int i = 0; i < 17; i++) send(1, -2048, i == 16);
      for (int i = 0; i < 16; i++) send(2, -2048, i == 15);
      for (int i = 0; i < 17; i++) send(3, 2047, 0);
      send(3, -2048, 1);
      idle(3);
   endtask

   task automatic test_clear_reset();
      send(3, 7, 0);
      send(1, 9, 0);
      clear = 1;
      send(3, 2, 1);
      clear = 0;
      send(1, 4, 1);
      idle(2);
      send(0, 9, 0);
      do_reset();
      send(0, 4, 1);
      idle(2);
      m_tready = 0;
      send(2, 11, 1);
      do_reset();
      m_tready = 1;
      total++;
      if (m_tvalid !== 1'b0) begin
         bad++;
         $display("FAIL reset_discard: got v=%0b want 0", m_tvalid);
      end
      idle(2);
   endtask

   task automatic test_bad_tid();
      send(1, 3, 0);
      send(4, 100, 1);
      total++;
      if (m_tvalid !== 1'b0) begin
         bad++;
         $display("FAIL bad_tid_result: got v=%0b want 0", m_tvalid);
      end
      send(7, -5, 0);
      send(1, 1, 1);
      idle(3);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         m_acc[i] = 0;
         m_ovf[i] = 0;
      end
      test_reset();
      test_basic();
      test_interleave();
      test_backpressure();
      test_overflow();
      test_clear_reset();
      test_bad_tid();
      idle(5);
      total++;
      if (q.size() !== 0) begin
         bad++;
         $display("FAIL missing_results: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stream_accumulator.md
# stream_accumulator

Parametrised, multi-channel, fixed-point AXI-Stream accumulator with backpressure.
- Sums signed input beats into per-channel running totals, selected by `s_axis_a_tid`.
- Emits the channel total and clears that channel on each `tlast` beat.
- Sits after the MAC array and before result writeback, in place of the single-channel, no-backpressure accumulator IP.
- Adds channel interleaving, `tready` flow control, overflow reporting and optional saturation.

## Interface
- `DATA_W`, 16: input sample width, signed two's complement.
- `ACC_W`, 32: accumulator and result width, signed; must be ≥ `DATA_W`.
- `CHANNELS`, 4: number of independent accumulators; ≥ 1.
- `ID_W`, 2: channel-id width; `CHANNELS` ≤ 2^`ID_W`.

Ports:
- `aclk`  in  1  clock, all logic on rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous pulse; zeroes all accumulators and overflow flags.
- `s_axis_a_tvalid`  in  1  input beat valid.
- `s_axis_a_tready`  out  1  input beat accepted when high with tvalid.
- `s_axis_a_tdata`  in  `DATA_W`  signed sample.
- `s_axis_a_tlast`  in  1  last beat of this channel's packet.
- `s_axis_a_tid`  in  `ID_W`  channel select.
- `m_axis_result_tvalid`  out  1  result valid.
- `m_axis_result_tready`  in  1  downstream accepts result.
- `m_axis_result_tdata`  out  `ACC_W`  packet sum.
- `m_axis_result_tlast`  out  1  always 1 when tvalid (one result per packet).
- `m_axis_result_tid`  out  `ID_W`  channel of the result.
- `m_axis_result_tuser`  out  1  overflow occurred anywhere in this packet.

## Operation
- Accept = `s_axis_a_tvalid & s_axis_a_tready`.
- Sample is sign-extended to `ACC_W`.
- `sum = acc[tid] + sext(tdata)`, computed at `ACC_W+1` bits.
- Overflow is detected when the two top bits of the `ACC_W+1` result differ.
- Non-last accept:
  - `acc[tid] <= sum` (wrapped or saturated).
  - `ovf[tid] |= overflow`.
- Last accept: the output register loads
  - `tdata = sum`
  - `tid`
  - `tuser = ovf[tid] | overflow`
  - `tvalid = 1`

  and `acc[tid] <= 0`, `ovf[tid] <= 0`.
- A single-beat packet (tlast on the first beat) outputs the sign-extended sample.
- `tid` ≥ `CHANNELS`: the beat is accepted and dropped with no state change. If it carries tlast, no result is produced.
- `clear`:
  - All acc/ovf go to 0 first.
  - A beat accepted in the same cycle then accumulates onto 0.
  - A pending output result is not affected.
- Output register is one entry. It holds until `m_axis_result_tready` is sampled high with tvalid.
- `s_axis_a_tready = !m_axis_result_tvalid | m_axis_result_tready`. The input stalls whenever an unconsumed result is pending, including for non-last beats.
- Reset: all acc/ovf = 0, output register cleared.
  - Reset mid-packet discards the partial sums.
  - Reset with a pending result discards that result.

## Timing
- Reset values:
  - `s_axis_a_tready` = 1 (combinational from output state).
  - `m_axis_result_tvalid`, `m_axis_result_tdata`, `m_axis_result_tlast`, `m_axis_result_tid`, `m_axis_result_tuser` = 0.
- Accumulate latency: 1 cycle. A beat accepted at edge N is visible to a same-channel beat at edge N+1, so back-to-back beats on one channel are allowed.
- Result latency: tlast accepted at edge N gives `m_axis_result_tvalid` high after edge N, presented in cycle N+1.
- Throughput: 1 beat/cycle when `m_axis_result_tready` is held high, including consecutive tlast beats on any channels.
- When a result is consumed and a new tlast is accepted at the same edge, the output reloads with no bubble.
- Output stays stable while tvalid & !tready (AXI-Stream rule).

## Configuration
- `ACCUM_SATURATE_EN`:
  - Defined: on overflow the stored/output value clamps to 2^(`ACC_W`-1)-1 (positive overflow) or -2^(`ACC_W`-1) (negative overflow).
  - Undefined: two's-complement wrap.
- The tuser overflow flag behaves identically in both builds.

## Test plan
- Reset, then ch0 beats 1, 2, 3 (last) with `m_axis_result_tready`=1 -> one result, tdata=6, tid=0, tuser=0, one cycle after the tlast accept.
- Interleave ch1: 10, ch2: -4, ch1: 5 (last), ch2: -6 (last) on consecutive cycles -> results ch1=15, then ch2=-10, in order, no stalls.
- Downstream tready=0 for 5 cycles after a tlast -> `s_axis_a_tready`=0, result held stable; tready=1 -> released, input resumes, no beat lost.
- `ACC_W`=16, ch0 beats 0x7FFF, 0x0001 (last) -> tuser=1, tdata=0x7FFF with `ACCUM_SATURATE_EN`, 0x8000 without.
- ch3 beat 7 (no last), pulse `clear` with beat 2 (last) on ch3 -> result 2; assert `areset` mid-packet on ch0 -> next packet 4 (last) yields 4.
- Beat with tid=4 on `CHANNELS`=4, `ID_W`=3, with tlast -> accepted, no result, all sums unchanged.
